// File: rtl/buffer_controller_pkg.sv
// Shared types and helpers for the buffer controller and its sub-blocks.
package buffer_controller_pkg;

  // Load sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of banks in a buffer with 2^depth banks
  function automatic int bank_count(input int depth);
    return 1 << depth;
  endfunction

endpackage

// File: rtl/buffer_controller_rr_arb2.sv
// Two-requester arbiter with alternating priority on contested cycles.
// Requester A is always granted when the arbiter is disabled; B only
// competes while enabled. The last-winner flag only moves while enabled.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic avail_b
);

  logic prio_a;

  // Remember who won last so the other side wins the next contest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_a <= 1'b1;
    end else if (en && gnt_a) begin
      prio_a <= 1'b0;
    end else if (en && gnt_b) begin
      prio_a <= 1'b1;
    end
  end

  // B may win whenever A is idle or it is B's turn; A takes anything B does not
  always_comb begin
    avail_b = en && (!req_a || !prio_a);
    gnt_b   = req_b && avail_b;
    gnt_a   = req_a && !gnt_b;
  end

endmodule

// File: rtl/buffer_controller.sv
// Sequences host word loads into a banked buffer and arbitrates the buffer
// between the host loader and the convolutional unit's row accesses.
module buffer_controller
  import buffer_controller_pkg::*;
#(
  parameter int depth = 2,
  parameter int A     = 7,
  parameter int W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ld_start,
  input  logic [A-1:0]     ld_base,
  input  logic [A:0]       ld_rows,
  input  logic             ld_valid,
  input  logic [W-1:0]     ld_data,
  output logic             ld_ready,
  output logic             ld_busy,
  output logic             ld_done,
  input  logic             cu_req,
  input  logic             cu_write,
  input  logic [A-1:0]     cu_addr,
  output logic             cu_gnt,
  output logic             cu_rvalid,
  output logic [A-1:0]     buf_address,
  output logic             buf_write,
  output logic             buf_ioSelect,
  output logic [depth-1:0] buf_ioBankSelect,
  output logic [W-1:0]     buf_ioInput
);

  localparam int D = bank_count(depth);

  state_t           state;
  state_t           state_next;
  logic [depth-1:0] bank_cnt;
  logic [A:0]       row_cnt;
  logic [A:0]       rows;
  logic [A-1:0]     base;
  logic [A-1:0]     addr_q;
  logic [A-1:0]     row_addr;
  logic             in_load;
  logic             cu_win;
  logic             ld_acc;
  logic             ld_avail;
  logic             last_word;

  assign in_load   = (state == LOAD);
  assign row_addr  = base + row_cnt[A-1:0];
  assign last_word = (bank_cnt == depth'(D - 1)) && (row_cnt == rows - (A+1)'(1));

  rr_arb2 u_arb (
    .clk     (CLK),
    .rst     (RST),
    .en      (in_load),
    .req_a   (cu_req),
    .req_b   (ld_valid),
    .gnt_a   (cu_win),
    .gnt_b   (ld_acc),
    .avail_b (ld_avail)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and load status flags
  always_comb begin
    state_next = state;
    ld_busy    = 1'b0;
    ld_done    = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start) begin
          state_next = (ld_rows == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        ld_busy = 1'b1;
        if (ld_acc && last_word) begin
          state_next = DONE;
        end
      end
      DONE: begin
        ld_busy    = 1'b1;
        ld_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job capture and bank/row progress; banks advance first, rows on wrap
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      base     <= '0;
      rows     <= '0;
      bank_cnt <= '0;
      row_cnt  <= '0;
    end else if (state == IDLE && ld_start) begin
      base     <= ld_base;
      rows     <= ld_rows;
      bank_cnt <= '0;
      row_cnt  <= '0;
    end else if (ld_acc) begin
      bank_cnt <= bank_cnt + depth'(1);
      if (bank_cnt == depth'(D - 1)) begin
        row_cnt <= row_cnt + (A+1)'(1);
      end
    end
  end

  // Buffer control mux; the address holds its last driven value when nobody is granted
  always_comb begin
    cu_gnt           = cu_win && !RST;
    ld_ready         = ld_avail;
    buf_write        = 1'b0;
    buf_ioSelect     = 1'b0;
    buf_address      = addr_q;
    buf_ioBankSelect = bank_cnt;
    buf_ioInput      = ld_data;
    if (ld_acc) begin
      buf_write    = 1'b1;
      buf_ioSelect = 1'b1;
      buf_address  = row_addr;
    end else if (cu_gnt) begin
      buf_write    = cu_write;
      buf_address  = cu_addr;
    end
  end

  // Held address and read-valid flag that tracks the SRAM's one-cycle read latency
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q    <= '0;
      cu_rvalid <= 1'b0;
    end else begin
      addr_q    <= buf_address;
      cu_rvalid <= cu_gnt && !cu_write;
    end
  end

endmodule

// File: tb/tb_buffer_controller.sv
// Self-checking bench for buffer_controller with a behavioural SRAM and a
// word-count based reference model of the load sequencer and arbiter.
module tb_buffer_controller;

  localparam int DEPTH = 2;
  localparam int A     = 7;
  localparam int W     = 16;
  localparam int D     = 4;
  localparam int NADDR = 128;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             ld_start = 1'b0;
  logic [A-1:0]     ld_base = '0;
  logic [A:0]       ld_rows = '0;
  logic             ld_valid = 1'b0;
  logic [W-1:0]     ld_data = '0;
  logic             ld_ready;
  logic             ld_busy;
  logic             ld_done;
  logic             cu_req = 1'b0;
  logic             cu_write = 1'b0;
  logic [A-1:0]     cu_addr = '0;
  logic             cu_gnt;
  logic             cu_rvalid;
  logic [A-1:0]     buf_address;
  logic             buf_write;
  logic             buf_ioSelect;
  logic [DEPTH-1:0] buf_ioBankSelect;
  logic [W-1:0]     buf_ioInput;

  logic [D*W-1:0]   ip = '0;
  logic [D*W-1:0]   op;
  logic             mem_clear = 1'b1;
  logic [W-1:0]     sram [D][NADDR];

  int checks = 0;
  int passes = 0;

  // Reference model: job progress is a single count of accepted words
  int               m_state;
  int               m_base;
  int               m_rows;
  int               m_k;
  bit               m_prio_cu;
  int               m_hold;
  bit               m_rvalid;
  logic [D*W-1:0]   m_rdata;
  logic [W-1:0]     mmem [D][NADDR];

  buffer_controller #(.depth(DEPTH), .A(A), .W(W)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .ld_start         (ld_start),
    .ld_base          (ld_base),
    .ld_rows          (ld_rows),
    .ld_valid         (ld_valid),
    .ld_data          (ld_data),
    .ld_ready         (ld_ready),
    .ld_busy          (ld_busy),
    .ld_done          (ld_done),
    .cu_req           (cu_req),
    .cu_write         (cu_write),
    .cu_addr          (cu_addr),
    .cu_gnt           (cu_gnt),
    .cu_rvalid        (cu_rvalid),
    .buf_address      (buf_address),
    .buf_write        (buf_write),
    .buf_ioSelect     (buf_ioSelect),
    .buf_ioBankSelect (buf_ioBankSelect),
    .buf_ioInput      (buf_ioInput)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  // Banked synchronous SRAM standing in for BufferMemory
  always @(posedge CLK) begin
    if (mem_clear) begin
      for (int b = 0; b < D; b++)
        for (int a = 0; a < NADDR; a++)
          sram[b][a] <= '0;
    end else begin
      for (int b = 0; b < D; b++)
        op[b*W +: W] <= sram[b][buf_address];
      if (buf_write) begin
        if (buf_ioSelect) begin
          sram[buf_ioBankSelect][buf_address] <= buf_ioInput;
        end else begin
          for (int b = 0; b < D; b++)
            sram[b][buf_address] <= ip[b*W +: W];
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      passes++;
    end
  endtask

  task automatic modelReset();
    m_state   = 0;
    m_base    = 0;
    m_rows    = 0;
    m_k       = 0;
    m_prio_cu = 1'b1;
    m_hold    = 0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
  endtask

  task automatic checkReset();
    checkOutput("rst_cu_gnt", cu_gnt, 0);
    checkOutput("rst_cu_rvalid", cu_rvalid, 0);
    checkOutput("rst_ld_ready", ld_ready, 0);
    checkOutput("rst_ld_busy", ld_busy, 0);
    checkOutput("rst_ld_done", ld_done, 0);
    checkOutput("rst_buf_write", buf_write, 0);
    checkOutput("rst_buf_ioSelect", buf_ioSelect, 0);
    checkOutput("rst_buf_address", buf_address, 0);
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model
  task automatic applyStimulus(input bit start, input logic [A-1:0] base, input logic [A:0] rows,
                               input bit valid, input logic [W-1:0] data, input bit req,
                               input bit wr, input logic [A-1:0] addr, input logic [D*W-1:0] row);
    bit loading;
    bit e_rdy;
    bit e_acc;
    bit e_cu;
    int e_addr;
    int old_state;
    ld_start = start;
    ld_base  = base;
    ld_rows  = rows;
    ld_valid = valid;
    ld_data  = data;
    cu_req   = req;
    cu_write = wr;
    cu_addr  = addr;
    ip       = row;
    #4;
    loading = (m_state == 1);
    e_rdy   = loading && (!req || !m_prio_cu);
    e_acc   = e_rdy && valid;
    e_cu    = req && !e_acc;
    if (e_acc)     e_addr = (m_base + m_k / D) % NADDR;
    else if (e_cu) e_addr = int'(addr);
    else           e_addr = m_hold;
    checkOutput("ld_ready", ld_ready, e_rdy);
    checkOutput("cu_gnt", cu_gnt, e_cu);
    checkOutput("ld_busy", ld_busy, m_state != 0);
    checkOutput("ld_done", ld_done, m_state == 2);
    checkOutput("buf_write", buf_write, e_acc || (e_cu && wr));
    checkOutput("buf_ioSelect", buf_ioSelect, e_acc);
    checkOutput("buf_address", buf_address, e_addr);
    checkOutput("buf_ioBankSelect", buf_ioBankSelect, m_k % D);
    checkOutput("buf_ioInput", buf_ioInput, data);
    checkOutput("cu_rvalid", cu_rvalid, m_rvalid);
    if (m_rvalid) checkOutput("op", op, m_rdata);
    @(posedge CLK);
    old_state = m_state;
    m_rvalid  = e_cu && !wr;
    if (e_cu && !wr)
      for (int b = 0; b < D; b++) m_rdata[b*W +: W] = mmem[b][addr];
    if (e_cu && wr)
      for (int b = 0; b < D; b++) mmem[b][addr] = row[b*W +: W];
    if (e_acc) begin
      mmem[m_k % D][e_addr] = data;
      m_k++;
    end
    if (loading && (e_acc || e_cu)) m_prio_cu = e_acc;
    m_hold = e_addr;
    case (old_state)
      0: if (start) begin
        m_base  = int'(base);
        m_rows  = int'(rows);
        m_k     = 0;
        m_state = (rows == 0) ? 2 : 1;
      end
      1: if (e_acc && m_k == m_rows * D) m_state = 2;
      default: m_state = 0;
    endcase
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, '0, '0, 0, '0, 0, 0, '0, '0);
  endtask

  task automatic startJob(input logic [A-1:0] base, input logic [A:0] rows);
    applyStimulus(1, base, rows, 0, '0, 0, 0, '0, '0);
  endtask

  task automatic pushWord(input logic [W-1:0] data);
    applyStimulus(0, '0, '0, 1, data, 0, 0, '0, '0);
  endtask

  task automatic readRow(input logic [A-1:0] addr);
    applyStimulus(0, '0, '0, 0, '0, 1, 0, addr, '0);
  endtask

  task automatic pulseReset();
    #2 RST = 1'b1;
    #1 checkReset();
    @(posedge CLK);
    #1 RST = 1'b0;
    modelReset();
  endtask

  initial begin
    int n;
    logic [A-1:0] r_base;
    logic [A:0]   r_rows;
    logic [W-1:0] r_data;
    logic [A-1:0] r_addr;
    logic [D*W-1:0] r_row;

    for (int b = 0; b < D; b++)
      for (int a = 0; a < NADDR; a++)
        mmem[b][a] = '0;
    modelReset();

    // Power-on reset with a CU request pending
    cu_req   = 1'b1;
    cu_write = 1'b1;
    #2 checkReset();
    cu_req   = 1'b0;
    cu_write = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b0;
    mem_clear = 1'b0;

    $display("[TB] reset in the middle of a load");
    startJob(7'd9, 8'd3);
    for (int i = 0; i < 3; i++) pushWord(16'h0a00 + 16'(i));
    pulseReset();
    startJob(7'd0, 8'd1);
    for (int i = 0; i < 4; i++) pushWord(16'h0b00 + 16'(i));
    idleCycle();
    readRow(7'd9);
    idleCycle();
    readRow(7'd0);
    idleCycle();

    $display("[TB] back-to-back load base=5 rows=2");
    startJob(7'd5, 8'd2);
    for (int i = 0; i < 8; i++) pushWord(16'h1000 + 16'(i));
    idleCycle();
    readRow(7'd6);
    checkOutput("row6_data", op, 64'h1007_1006_1005_1004);
    idleCycle();

    $display("[TB] contested load");
    pulseReset();
    startJob(7'd20, 8'd2);
    n = 0;
    while (m_state == 1 && n < 40) begin
      applyStimulus(0, '0, '0, 1, 16'h2000 + 16'(m_k), 1, 0, 7'(n), '0);
      n++;
    end
    checkOutput("contest_cycles", n, 16);
    idleCycle();
    readRow(7'd21);
    checkOutput("row21_data", op, 64'h2007_2006_2005_2004);
    idleCycle();

    $display("[TB] zero-row job");
    startJob(7'd33, 8'd0);
    idleCycle();
    idleCycle();

    $display("[TB] address wrap");
    startJob(7'd127, 8'd2);
    for (int i = 0; i < 8; i++) pushWord(16'h3000 + 16'(i));
    idleCycle();
    readRow(7'd127);
    checkOutput("row127_data", op, 64'h3003_3002_3001_3000);
    readRow(7'd0);
    checkOutput("row0_data", op, 64'h3007_3006_3005_3004);
    idleCycle();

    $display("[TB] start ignored during load");
    startJob(7'd40, 8'd1);
    pushWord(16'h4000);
    pushWord(16'h4001);
    applyStimulus(1, 7'd100, 8'd5, 1, 16'h4002, 0, 0, '0, '0);
    applyStimulus(1, 7'd100, 8'd5, 1, 16'h4003, 0, 0, '0, '0);
    idleCycle();
    idleCycle();
    checkOutput("start_ignored_idle", ld_busy, 0);
    readRow(7'd40);
    checkOutput("row40_data", op, 64'h4003_4002_4001_4000);
    idleCycle();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 800; c++) begin
      r_base = 7'($urandom);
      r_rows = 8'($urandom_range(0, 3));
      r_data = 16'($urandom);
      r_addr = 7'($urandom);
      r_row  = {$urandom, $urandom};
      applyStimulus($urandom_range(0, 7) == 0, r_base, r_rows, $urandom_range(0, 3) != 0,
                    r_data, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, r_addr, r_row);
    end
    for (int c = 0; c < 40 && m_state != 0; c++) pushWord(16'($urandom));
    idleCycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/buffer_controller.md
Name: buffer_controller

Overview:
- Sequences and arbitrates one BufferMemory instance (D = 2^depth banks, A-bit address, W-bit words) between two requesters:
  - a host loader that streams single W-bit words bank-by-bank (io path);
  - the convolutional unit, which reads or writes full D-wide rows.
- Drives the buffer's address, write, ioSelect, ioBankSelect and ioInput controls.
- The CU row data bus (ip/op) connects directly between CU and buffer; it does not pass through this block.

Parameters:
- depth, 2, log2 of bank count; D = 1<<depth.
- A, 7, buffer address width.
- W, 16, word width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ld_start  in  1  start a load job; sampled only in IDLE.
- ld_base  in  A  first row address of the job; captured on ld_start.
- ld_rows  in  A+1  number of rows to load; captured on ld_start.
- ld_valid  in  1  host word valid.
- ld_data  in  W  host word.
- ld_ready  out  1  word accepted this cycle when ld_valid && ld_ready.
- ld_busy  out  1  high in LOAD and DONE.
- ld_done  out  1  one-cycle completion pulse.
- cu_req  in  1  CU row access request.
- cu_write  in  1  1 = row write, 0 = row read.
- cu_addr  in  A  row address.
- cu_gnt  out  1  request serviced this cycle (combinational).
- cu_rvalid  out  1  registered; op holds read data this cycle.
- buf_address  out  A  to buffer address.
- buf_write  out  1  to buffer write.
- buf_ioSelect  out  1  to buffer ioSelect.
- buf_ioBankSelect  out  depth  to buffer ioBankSelect.
- buf_ioInput  out  W  to buffer ioInput.

Behaviour:
- Buffer model: synchronous SRAM. Writes commit on the CLK edge. Read data appears on op one cycle after the address is presented.
- FSM states:
  - IDLE: ld_start=1 captures ld_base/ld_rows, clears bank_cnt and row_cnt. Goes to DONE if ld_rows==0, else LOAD.
  - LOAD: each accepted word increments bank_cnt. On wrap to 0, row_cnt increments. Accepting the last word (bank_cnt==D-1 and row_cnt==rows-1) goes to DONE.
  - DONE: ld_done=1 for exactly one cycle, then IDLE.
- ld_start is ignored outside IDLE.
- Arbitration occurs only in LOAD, when both cu_req and ld_valid are high:
  - Alternate priority using a last-winner flag.
  - After reset the flag is set so the first contested cycle goes to the CU.
  - Uncontested requests are always granted.
  - In IDLE/DONE, cu_gnt = cu_req.
- Loader grant (ld_ready=1 with ld_valid=1), combinational outputs:
  - buf_ioSelect=1, buf_write=1
  - buf_ioBankSelect=bank_cnt
  - buf_address=(base+row_cnt) mod 2^A (wraps silently)
  - buf_ioInput=ld_data
- ld_ready is high in LOAD whenever the loader would win arbitration. It may be high with ld_valid low.
- CU grant outputs: buf_ioSelect=0, buf_address=cu_addr, buf_write=cu_write.
  - A read sets cu_rvalid=1 on the next cycle.
  - A write takes effect on all banks on the grant edge.
- No grant outputs: buf_write=0, buf_ioSelect=0, buf_address holds its previous value, buf_ioBankSelect=bank_cnt, buf_ioInput=ld_data.
- Reset (async, any time, including mid-load):
  - state=IDLE; counters, base and rows cleared; priority flag set.
  - cu_rvalid=0, ld_done=0, ld_busy=0, ld_ready=0, cu_gnt=0.
  - buf_write=0, buf_ioSelect=0, buf_address=0.
  - A partial load is abandoned; already-written words stay in the SRAM.
- ld_rows max is 2^A; that load covers the full buffer exactly once.

Decomposition:
- Shared package: FSM state encoding (IDLE, LOAD, DONE) and a D = 1<<depth helper constant.
- Sub-module rr_arb2: a two-requester alternating-priority arbiter holding the last-winner flag. Reusable for other buffers.
- Counters and FSM stay in buffer_controller.

Test Plan (depth=2, A=7, W=16):
- Reset mid-LOAD after 3 words -> all outputs at reset values. Next ld_start(base=0, rows=1) restarts at bank 0, row 0.
- ld_start base=5, rows=2, 8 back-to-back words 0x1000..0x1007, no CU traffic:
  - buf_address goes 5,5,5,5,6,6,6,6; buf_ioBankSelect goes 0,1,2,3,0,1,2,3.
  - ld_done pulses once, the cycle after the 8th accept.
  - CU read of row 6 then returns op = {0x1007,0x1006,0x1005,0x1004}.
- cu_req continuously high with ld_valid high during LOAD -> grants alternate CU, loader, CU, loader. No word is lost; the load takes 2x the cycles.
- ld_start with rows=0 -> ld_busy high 1 cycle, ld_done pulses the next cycle, no buffer write.
- Wrap: base=127, rows=2 -> row 0 written at address 127, row 1 at address 0.
- ld_start asserted while in LOAD -> ignored; captured base/rows are unchanged and the job completes normally.
